seg7_scan_driver: RTL

Parametrised multiplexed seven-segment display driver for N digits. It accepts a signed or unsigned binary value through a valid/ready handshake and converts it to BCD with an internal iterative double-dabble engine. It also handles sign, overflow and decimal-point display, and scans the digits with a programmable refresh divider and an inter-digit ghosting guard. It sits between the position/setpoint/velocity datapath and the board's segment/enable pins, and replaces the free-running converter plus hand-coded 3-digit scan in the top level.

---
 rtl/seg7_scan_driver.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment driver with iterative double-dabble BCD.
// Define SEG7_LZB_EN to compile in leading-zero blanking.
module seg7_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int INPUT_WIDTH = 16,
  parameter int SCAN_DIV    = 32768
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [INPUT_WIDTH-1:0] i_value,
  input  logic                   i_signed,
  input  logic [3:0]             i_dp_pos,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic                   o_done,
  output logic [7:0]             o_seg,
  output logic [DIGITS-1:0]      o_an
);
  localparam int CD = (INPUT_WIDTH + 2) / 3;
  localparam int PD = (CD > DIGITS) ? CD : DIGITS;
  localparam int CW = $clog2(INPUT_WIDTH);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [6:0] G_MINUS = 7'b1111110;
  localparam logic [6:0] G_BLANK = 7'b1111111;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [INPUT_WIDTH-1:0]  sh_q, sh_d;
  logic [4*CD-1:0]         bcd_q, bcd_d, adj;
  logic                    neg_q, neg_d;
  logic [3:0]              dp_q, dp_d;
  logic [DIGITS-1:0][6:0]  glyph_q, glyph_d, glyph_n;
  logic [DIGITS-1:0]       dpm_q, dpm_d, dpm_n;
  logic                    done_q, done_d;
  logic [DW-1:0]           div_q, div_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [7:0]              seg_q, seg_d;
  logic [DIGITS-1:0]       an_q, an_d;
  logic [4*PD-1:0]         bcdp;
  logic                    ovf;
  int                      keep, mpos;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    unique case (d)
      4'd0:    seg_of = 7'b0000001;
      4'd1:    seg_of = 7'b1001111;
      4'd2:    seg_of = 7'b0010010;
      4'd3:    seg_of = 7'b0000110;
      4'd4:    seg_of = 7'b1001100;
      4'd5:    seg_of = 7'b0100100;
      4'd6:    seg_of = 7'b0100000;
      4'd7:    seg_of = 7'b0001111;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0001100;
      default: seg_of = G_BLANK;
    endcase
  endfunction

  // Display image built from the finished accumulator
  always_comb begin
    bcdp = '0;
    bcdp[4*CD-1:0] = bcd_q;
    ovf = neg_q && (bcdp[4*(DIGITS-1)+:4] != 4'd0);
    for (int k = DIGITS; k < PD; k++)
      if (bcdp[4*k+:4] != 4'd0) ovf = 1'b1;
`ifdef SEG7_LZB_EN
    keep = 0;
    for (int k = 1; k < DIGITS; k++)
      if (bcdp[4*k+:4] != 4'd0) keep = k;
    if (int'(dp_q) < DIGITS && int'(dp_q) > keep)
      keep = int'(dp_q);
    mpos = (keep < DIGITS - 1) ? keep + 1 : DIGITS - 1;
`else
    keep = DIGITS - 1;
    mpos = DIGITS - 1;
`endif
    for (int k = 0; k < DIGITS; k++) begin
      glyph_n[k] = (k > keep) ? G_BLANK : seg_of(bcdp[4*k+:4]);
      if (neg_q && k == mpos) glyph_n[k] = G_MINUS;
      if (ovf) glyph_n[k] = G_MINUS;
      dpm_n[k] = !ovf && (int'(dp_q) == k);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    dp_d    = dp_q;
    glyph_d = glyph_q;
    dpm_d   = dpm_q;
    done_d  = 1'b0;
    adj     = bcd_q;
    for (int k = 0; k < CD; k++)
      if (adj[4*k+:4] >= 4'd5) adj[4*k+:4] = adj[4*k+:4] + 4'd3;
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          neg_d   = i_signed && i_value[INPUT_WIDTH-1];
          sh_d    = neg_d ? -i_value : i_value;
          dp_d    = i_dp_pos;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = {adj[4*CD-2:0], sh_q[INPUT_WIDTH-1]};
        sh_d  = {sh_q[INPUT_WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(INPUT_WIDTH - 1)) state_d = COMMIT;
      end
      COMMIT: begin
        glyph_d = glyph_n;
        dpm_d   = dpm_n;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    div_d = (div_q == DW'(SCAN_DIV - 1)) ? '0 : div_q + DW'(1);
    idx_d = idx_q;
    if (div_q == DW'(SCAN_DIV - 1))
      idx_d = (idx_q == '0) ? IW'(DIGITS - 1) : idx_q - IW'(1);
    // First two counts of a slot dark to avoid ghosting
    if (div_q < DW'(2)) begin
      an_d  = '1;
      seg_d = 8'hFF;
    end else begin
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = {glyph_q[idx_q], ~dpm_q[idx_q]};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      dp_q    <= '1;
      glyph_q <= {DIGITS{G_BLANK}};
      dpm_q   <= '0;
      done_q  <= 1'b0;
      div_q   <= '0;
      idx_q   <= IW'(DIGITS - 1);
      seg_q   <= 8'hFF;
      an_q    <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      dp_q    <= dp_d;
      glyph_q <= glyph_d;
      dpm_q   <= dpm_d;
      done_q  <= done_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_done  = done_q;
  assign o_seg   = seg_q;
  assign o_an    = an_q;
endmodule
